serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that sums two WIDTH-bit operands one bit per clock using the existing single-bit FA cell as its datapath, with a registered carry fed back into the FA carry-in between bits. It sits directly around the FA stage: it feeds the FA one operand bit pair plus the stored carry each cycle and consumes the FA sum/carry outputs into a result shift register. A start/busy/done handshake lets a controller launch one addition at a time and collect a held result.

## Interface

Reset: one clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch request, sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on the accepted start
- b  input  WIDTH  operand B, captured on the accepted start
- cin  input  1  initial carry-in, captured on the accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse: sum/cout newly valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered final carry, held with sum

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 → capture a, b into shift registers, carry register ← cin, bit counter ← 0, go to RUN.
- RUN: busy=1. FA inputs: ain = LSB of A shift reg, bin = LSB of B shift reg, cin = carry register. Each edge: A and B shift right by one, FA sout enters MSB of the partial-sum shift register, carry register ← FA cout, counter increments. start is ignored.
- After the WIDTH-th bit edge: sum ← partial-sum register (including that last bit), cout ← FA cout, go to DONE.
- DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- sum/cout change only on completion; during RUN they hold the previous result.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH+1); terminal count WIDTH-1 at the bit being processed.
- Reset at any time (including mid-RUN): abort, return to IDLE, all outputs and internal registers cleared; no done pulse for the aborted operation.

## Timing

- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE.
- start accepted at edge E0 → busy high from E0 to E_WIDTH.
- Bit i (LSB = 0) processed at edge E(i+1).
- At E_WIDTH: sum/cout updated, done high for the cycle E_WIDTH..E_(WIDTH+1), busy low.
- Latency start → done = WIDTH+1 cycles; throughput one operation per WIDTH+1 cycles with back-to-back start.
- start held high continuously: new operation accepted in DONE each time; operands are sampled at that edge.

## Structure

- Shared package serial_adder_pkg: state encoding constants (IDLE, RUN, DONE) and default width constant.
- One sub-module: FA (existing cell, ports cin, ain, bin, sout, cout), instantiated once as the bit datapath; the FSM, shift registers, carry flop and counter live in serial_adder.

## Test plan

- Reset, then a=0x00, b=0x00, cin=0, start one cycle → done pulses 9 cycles after start, sum=0x00, cout=0; busy high exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1 (full carry ripple across all bits).
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1; a=0x3C, b=0x42, cin=0 → sum=0x7E, cout=0.
- Launch a=0x10, b=0x20; pulse start with a=0xFF, b=0xFF at cycle 3 of RUN → ignored; result sum=0x30, cout=0, single done pulse.
- Assert rst_n low in cycle 4 of RUN, release, wait 12 cycles → no done pulse, busy=0, sum=0x00, cout=0; subsequent a=0x01, b=0x01 → sum=0x02.
- Hold start high with a=0x80, b=0x80, cin=0 then change operands to 0x01, 0x02 during RUN → first done gives sum=0x00, cout=1; second done (9 cycles later) gives sum=0x03, cout=0; sum holds 0x00 throughout the second RUN.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - single-bit full adder cell used as the serial datapath
module fa (
  input  logic cin,
  input  logic ain,
  input  logic bin,
  output logic sout,
  output logic cout
);

  assign sout = ain ^ bin ^ cin;
  assign cout = (ain & bin) | (ain & cin) | (bin & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one FA cell with start/busy/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sout;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  fa u_fa (
    .cin  (carry),
    .ain  (a_sh[0]),
    .bin  (b_sh[0]),
    .sout (fa_sout),
    .cout (fa_cout)
  );

  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  // Earlier bits sit in psum; the bit produced this cycle completes the word.
  assign psum_next = {fa_sout, psum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      psum  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      psum  <= psum_next[WIDTH-1:1];
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= psum_next;
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One start pulse, then wait (bounded) for done; checks latency, busy length and result.
  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic c, input logic [7:0] es, input logic ec);
    int  lat;
    int  busy_cnt;
    bit  got;
    @(negedge clk);
    a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) busy_cnt++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n_done;
    int hold_bad;
    int lat;
    bit got;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    do_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_add("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    do_add("3c_42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

    // start during RUN must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("ign_done_count", 32'(n_done), 32'd1);
    check("ign_sum", 32'(sum), 32'h30);
    check("ign_cout", 32'(cout), 32'd0);

    // reset mid-RUN aborts without a done pulse
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_async", 32'(busy), 32'd0);
    check("abort_sum_async", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    do_add("post_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // start held high: back-to-back operations, operands sampled at the DONE edge
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_sum", 32'(sum), 32'h00);
    check("b2b_first_cout", 32'(cout), 32'd1);
    got = 0; lat = 0; hold_bad = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      else if (sum !== 8'h00 || cout !== 1'b1) hold_bad++;
    end
    start = 1'b0;
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_gap", 32'(lat), 32'd9);
    check("b2b_hold", 32'(hold_bad), 32'd0);
    check("b2b_second_sum", 32'(sum), 32'h03);
    check("b2b_second_cout", 32'(cout), 32'd0);
    repeat (3) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
